// File: rtl/freq_to_ascii_seq_pkg.sv
// Shared definitions for the frequency-to-ASCII converter.
//   - ASCII code points used by the formatter
//   - FSM state encoding
//   - cfg_ok(): elaboration-time legality check of the BCD sizing parameters
package freq_to_ascii_seq_pkg;

   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_NINE  = 8'h39;

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StFormat
   } state_t;

   // 10^bcd_digits > 2^in_width holds iff bcd_digits >= floor(in_width*log10(2)) + 1.
   // 2^n is never a power of ten, so the floor of the fixed-point product is exact enough.
   function automatic bit cfg_ok(input int unsigned in_width,
                                 input int unsigned bcd_digits,
                                 input int unsigned skip_digits,
                                 input int unsigned digits);
      int unsigned needed;
      needed = (in_width * 30103) / 100000 + 1;
      return (bcd_digits >= needed) && (digits >= 1) && (skip_digits + digits <= bcd_digits);
   endfunction

endpackage

// File: rtl/freq_to_ascii_seq_bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD nibble of 5 or more so that the
// following left shift carries correctly into the next decimal digit.
//   din  : BCD digit before correction
//   dout : corrected digit
module bcd_digit_adj (
   input  logic [3:0] din,
   output logic [3:0] dout
);

   always_comb begin
      dout = (din >= 4'd5) ? din + 4'd3 : din;
   end

endmodule

// File: rtl/freq_to_ascii_seq.sv
// Sequential binary-to-decimal-ASCII converter (shift-add-3).
// One conversion takes IN_WIDTH+1 cycles from an accepted START to the DONE pulse.
//   CLK   : system clock, rising edge
//   RST   : synchronous active-high reset, priority over START
//   START : one-cycle request, FREQ sampled when idle
//   FREQ  : unsigned binary input
//   BUSY  : conversion in progress
//   DONE  : one-cycle pulse, ASCII/OVF updated
//   OVF   : FREQ >= 10^(SKIP_DIGITS+DIGITS), held with ASCII
//   ASCII : 8*DIGITS result, [7:0] = least significant displayed digit
module freq_to_ascii_seq
   import freq_to_ascii_seq_pkg::*;
#(
   parameter int unsigned IN_WIDTH    = 32,
   parameter int unsigned BCD_DIGITS  = 10,
   parameter int unsigned SKIP_DIGITS = 3,
   parameter int unsigned DIGITS      = 5,
   parameter bit          BLANK       = 1'b0
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  START,
   input  logic [IN_WIDTH-1:0]   FREQ,
   output logic                  BUSY,
   output logic                  DONE,
   output logic                  OVF,
   output logic [8*DIGITS-1:0]   ASCII
);

   localparam int unsigned BCD_W = 4 * BCD_DIGITS;
   localparam int unsigned CNT_W = $clog2(IN_WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(IN_WIDTH - 1);

   if (!cfg_ok(IN_WIDTH, BCD_DIGITS, SKIP_DIGITS, DIGITS)) begin : g_cfg_check
      $error("freq_to_ascii_seq: BCD_DIGITS/SKIP_DIGITS/DIGITS inconsistent with IN_WIDTH");
   end

   // Formatted zero, used as the reset value of ASCII.
   function automatic logic [8*DIGITS-1:0] reset_ascii();
      logic [8*DIGITS-1:0] r;
      r = '0;
      for (int i = 0; i < int'(DIGITS); i++) begin
         r[8*i +: 8] = (BLANK && i != 0) ? ASCII_SPACE : ASCII_ZERO;
      end
      return r;
   endfunction

   localparam logic [8*DIGITS-1:0] ASCII_RESET = reset_ascii();

   state_t               state;
   logic [CNT_W-1:0]     cnt;
   logic [IN_WIDTH-1:0]  shift_reg;
   logic [BCD_W-1:0]     bcd;
   logic [BCD_W-1:0]     bcd_adj;
   logic [BCD_W-1:0]     bcd_next;
   logic [IN_WIDTH-1:0]  shift_next;
   logic [8*DIGITS-1:0]  fmt_ascii;
   logic                 fmt_ovf;
   logic                 unused_adj_msb;

   for (genvar g = 0; g < int'(BCD_DIGITS); g++) begin : g_adj
      bcd_digit_adj u_adj (
         .din  (bcd[4*g +: 4]),
         .dout (bcd_adj[4*g +: 4])
      );
   end

   // The top BCD bit never sets because 10^BCD_DIGITS > 2^IN_WIDTH.
   assign unused_adj_msb = bcd_adj[BCD_W-1];

   always_comb begin
      bcd_next = {bcd_adj[BCD_W-2:0], shift_reg[IN_WIDTH-1]};
      shift_next = {shift_reg[IN_WIDTH-2:0], 1'b0};
   end

   // Formatter: digits above the displayed field flag overflow and saturate to all nines.
   always_comb begin
      logic       lead;
      logic [3:0] digit;
      fmt_ovf   = 1'b0;
      fmt_ascii = '0;
      lead      = BLANK;
      digit     = '0;
      for (int i = int'(SKIP_DIGITS + DIGITS); i < int'(BCD_DIGITS); i++) begin
         if (bcd[4*i +: 4] != 4'd0) begin
            fmt_ovf = 1'b1;
         end
      end
      for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
         digit = bcd[4*(int'(SKIP_DIGITS) + i) +: 4];
         if (fmt_ovf) begin
            fmt_ascii[8*i +: 8] = ASCII_NINE;
         end else if (lead && digit == 4'd0 && i != 0) begin
            fmt_ascii[8*i +: 8] = ASCII_SPACE;
         end else begin
            fmt_ascii[8*i +: 8] = ASCII_ZERO + {4'd0, digit};
            lead = 1'b0;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= StIdle;
         cnt       <= '0;
         shift_reg <= '0;
         bcd       <= '0;
         BUSY      <= 1'b0;
         DONE      <= 1'b0;
         OVF       <= 1'b0;
         ASCII     <= ASCII_RESET;
      end else begin
         DONE <= 1'b0;
         case (state)
            StIdle: begin
               if (START) begin
                  shift_reg <= FREQ;
                  bcd       <= '0;
                  cnt       <= '0;
                  BUSY      <= 1'b1;
                  state     <= StShift;
               end
            end
            StShift: begin
               bcd       <= bcd_next;
               shift_reg <= shift_next;
               cnt       <= cnt + 1'b1;
               if (cnt == LAST_ITER) begin
                  state <= StFormat;
               end
            end
            StFormat: begin
               ASCII <= fmt_ascii;
               OVF   <= fmt_ovf;
               DONE  <= 1'b1;
               BUSY  <= 1'b0;
               state <= StIdle;
            end
            default: begin
               BUSY  <= 1'b0;
               state <= StIdle;
            end
         endcase
      end
   end

endmodule
